hpdcache_mshr_ctrl: RTL and testbench
=====================================

// Module: hpdcache_mshr_ctrl
// PURPOSE
//  Sequences hpdcache_mshr, whose single SRAM port is shared between two requesters:
//  core miss path (check then optional alloc) and refill path (ack). Issues at most one
//  MSHR command per cycle, never an ack concurrent with check/alloc, and never an ack
//  between a check and its alloc (no stale hit). Starvation-bounded ack priority.
// PARAMETERS
//  ACK_STREAK_MAX  4  max consecutive ack grants while a core request waits (>=1)
//  STREAK_W  $clog2(ACK_STREAK_MAX+1)  derived; not overridden
// PORTS
//  clk_i              in   1   clock
//  rst_i              in   1   asynchronous, active-high reset
//  core_req_valid_i   in   1   core request valid
//  core_req_ready_o   out  1   core request accepted when valid&ready
//  core_req_alloc_i   in   1   1: allocate on miss; 0: check-only
//  core_req_nline_i   in   NLINE_W  hpdcache_nline_t
//  core_req_id_i      in   hpdcache_req_tid_t   request tid
//  core_req_sid_i     in   hpdcache_req_sid_t   source id
//  core_req_word_i    in   hpdcache_word_t      word index
//  core_req_need_rsp_i/core_req_is_pf_i  in 1 each  forwarded to alloc
//  core_rsp_valid_o   out  1   one-cycle pulse: outcome of accepted request
//  core_rsp_hit_o     out  1   MSHR hit on nline
//  core_rsp_full_o    out  1   miss, MSHR set full, not allocated
//  core_rsp_alloc_o   out  1   allocated; way on core_rsp_way_o
//  core_rsp_way_o     out  mshr_way_t   allocated way
//  ack_req_valid_i    in   1   refill ack request
//  ack_req_ready_o    out  1   ack granted
//  ack_req_set_i/ack_req_way_i  in  mshr_set_t/mshr_way_t  entry to release
//  ack_rsp_valid_o    out  1   pulse 1 cycle after grant: MSHR ack_* outputs valid
//  mshr_check_o, mshr_check_set_o, mshr_check_tag_o  out  1/set/tag  to MSHR
//  mshr_hit_i, mshr_alloc_full_i, mshr_alloc_way_i   in   1/1/way    from MSHR
//  mshr_alloc_o, mshr_alloc_cs_o   out 1  alloc strobe/chip-select
//  mshr_alloc_nline_o/id_o/sid_o/word_o/need_rsp_o/is_pf_o  out  held request fields
//  mshr_ack_o, mshr_ack_cs_o       out 1  ack strobe/chip-select
//  mshr_ack_set_o, mshr_ack_way_o  out set/way
// BEHAVIOUR
//  FSM IDLE, CHECK, ALLOC; reset -> IDLE, streak=0, held request regs=0.
//  Reset: all strobes, *_valid_o, *_ready_o = 0 while rst_i high; mid-op reset aborts,
//   no rsp pulse after release.
//  IDLE arbitration (one winner): ack wins if ack_req_valid_i and
//   (!core_req_valid_i or streak<ACK_STREAK_MAX); else core wins if core_req_valid_i.
//  Streak: +1 per ack grant with core_req_valid_i high; cleared on core grant or when
//   core_req_valid_i low; saturates at ACK_STREAK_MAX.
//  Ack grant (IDLE only): ack_req_ready_o=1, mshr_ack_o=mshr_ack_cs_o=1 same cycle with
//   set/way; ack_rsp_valid_o=1 next cycle; state stays IDLE; back-to-back acks allowed.
//  Core grant: core_req_ready_o=1, mshr_check_o=1, set/tag = nline[0+:SET_W],
//   nline[SET_W+:TAG_W]; capture fields; -> CHECK.
//  CHECK (1 cycle, no grants): sample mshr_hit_i, mshr_alloc_full_i.
//   hit -> rsp hit=1, IDLE. else full -> rsp full=1, IDLE. else !alloc -> rsp with
//   hit=full=alloc=0, IDLE. else -> ALLOC. hit has priority over full.
//  ALLOC (1 cycle, no grants): mshr_alloc_o=mshr_alloc_cs_o=1 with held fields;
//   rsp alloc=1, way=mshr_alloc_way_i; -> IDLE.
//  Latency accept->rsp: 1 cycle (hit/full/check-only), 2 cycles (alloc); throughput
//   1 core request per 2 or 3 cycles. Exactly one rsp flag set per rsp pulse (except
//   check-only miss: none).
//  Invariant: mshr_check_o+mshr_alloc_o+mshr_ack_o <= 1 every cycle.
// STRUCTURE
//  hpdcache_pkg: hpdcache_mshr_ctrl_state_e {IDLE,CHECK,ALLOC}; mshr_* types reused.
//  Sub-module hpdcache_mshr_ctrl_arb: 2-input priority arbiter with streak counter
//   (inputs ack_valid, core_valid, enable=IDLE; outputs gnt_ack, gnt_core).
//  FSM, field holding registers, response generation in this module.
// TESTING
//  Core req nline=0x123, alloc=1, empty MSHR -> check set/tag, alloc cycle+2, rsp alloc=1 way=0.
//  Same nline again -> rsp hit=1 at cycle+1, no mshr_alloc_o.
//  Fill all ways of a set, new miss same set -> rsp full=1, no alloc strobe.
//  ack_req_valid_i held high 10 cycles + core valid, MAX=4 -> 4 acks, 1 core grant, repeat.
//  Ack and core valid while FSM in CHECK/ALLOC -> ack_req_ready_o=0 until IDLE.
//  rst_i asserted in ALLOC -> no strobe/rsp; after release IDLE, streak=0.

Source files
------------

// File: rtl/hpdcache_mshr_ctrl_pkg.sv
// hpdcache_mshr_ctrl_pkg: shared widths, MSHR types, FSM state and held-request record
package hpdcache_mshr_ctrl_pkg;
    localparam int NLINE_W = 16;
    localparam int SET_W   = 4;
    localparam int TAG_W   = NLINE_W - SET_W;
    localparam int WAYS    = 4;
    localparam int WAY_W   = 2;
    localparam int WORD_W  = 3;
    localparam int TID_W   = 4;
    localparam int SID_W   = 2;

    typedef logic [NLINE_W-1:0] hpdcache_nline_t;
    typedef logic [SET_W-1:0]   mshr_set_t;
    typedef logic [TAG_W-1:0]   mshr_tag_t;
    typedef logic [WAY_W-1:0]   mshr_way_t;
    typedef logic [WORD_W-1:0]  hpdcache_word_t;
    typedef logic [TID_W-1:0]   hpdcache_req_tid_t;
    typedef logic [SID_W-1:0]   hpdcache_req_sid_t;

    typedef enum logic [1:0] {IDLE, CHECK, ALLOC} hpdcache_mshr_ctrl_state_e;

    typedef struct packed {
        logic              alloc;
        hpdcache_nline_t   nline;
        hpdcache_req_tid_t id;
        hpdcache_req_sid_t sid;
        hpdcache_word_t    word;
        logic              need_rsp;
        logic              is_pf;
    } core_req_t;

    function automatic mshr_set_t nline_set(input hpdcache_nline_t nline);
        return nline[0+:SET_W];
    endfunction

    function automatic mshr_tag_t nline_tag(input hpdcache_nline_t nline);
        return nline[SET_W+:TAG_W];
    endfunction
endpackage

// File: rtl/hpdcache_mshr_ctrl_if.sv
// hpdcache_mshr_ctrl_if: core/refill request ports and MSHR command/status bundle
interface hpdcache_mshr_ctrl_if;
    import hpdcache_mshr_ctrl_pkg::*;

    logic              core_req_valid_i;
    logic              core_req_ready_o;
    logic              core_req_alloc_i;
    hpdcache_nline_t   core_req_nline_i;
    hpdcache_req_tid_t core_req_id_i;
    hpdcache_req_sid_t core_req_sid_i;
    hpdcache_word_t    core_req_word_i;
    logic              core_req_need_rsp_i;
    logic              core_req_is_pf_i;
    logic              core_rsp_valid_o;
    logic              core_rsp_hit_o;
    logic              core_rsp_full_o;
    logic              core_rsp_alloc_o;
    mshr_way_t         core_rsp_way_o;
    logic              ack_req_valid_i;
    logic              ack_req_ready_o;
    mshr_set_t         ack_req_set_i;
    mshr_way_t         ack_req_way_i;
    logic              ack_rsp_valid_o;
    logic              mshr_check_o;
    mshr_set_t         mshr_check_set_o;
    mshr_tag_t         mshr_check_tag_o;
    logic              mshr_hit_i;
    logic              mshr_alloc_full_i;
    mshr_way_t         mshr_alloc_way_i;
    logic              mshr_alloc_o;
    logic              mshr_alloc_cs_o;
    hpdcache_nline_t   mshr_alloc_nline_o;
    hpdcache_req_tid_t mshr_alloc_id_o;
    hpdcache_req_sid_t mshr_alloc_sid_o;
    hpdcache_word_t    mshr_alloc_word_o;
    logic              mshr_alloc_need_rsp_o;
    logic              mshr_alloc_is_pf_o;
    logic              mshr_ack_o;
    logic              mshr_ack_cs_o;
    mshr_set_t         mshr_ack_set_o;
    mshr_way_t         mshr_ack_way_o;

    modport slave (
        input  core_req_valid_i, core_req_alloc_i, core_req_nline_i, core_req_id_i,
               core_req_sid_i, core_req_word_i, core_req_need_rsp_i, core_req_is_pf_i,
               ack_req_valid_i, ack_req_set_i, ack_req_way_i,
               mshr_hit_i, mshr_alloc_full_i, mshr_alloc_way_i,
        output core_req_ready_o, core_rsp_valid_o, core_rsp_hit_o, core_rsp_full_o,
               core_rsp_alloc_o, core_rsp_way_o, ack_req_ready_o, ack_rsp_valid_o,
               mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
               mshr_alloc_o, mshr_alloc_cs_o, mshr_alloc_nline_o, mshr_alloc_id_o,
               mshr_alloc_sid_o, mshr_alloc_word_o, mshr_alloc_need_rsp_o, mshr_alloc_is_pf_o,
               mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o
    );

    modport master (
        output core_req_valid_i, core_req_alloc_i, core_req_nline_i, core_req_id_i,
               core_req_sid_i, core_req_word_i, core_req_need_rsp_i, core_req_is_pf_i,
               ack_req_valid_i, ack_req_set_i, ack_req_way_i,
               mshr_hit_i, mshr_alloc_full_i, mshr_alloc_way_i,
        input  core_req_ready_o, core_rsp_valid_o, core_rsp_hit_o, core_rsp_full_o,
               core_rsp_alloc_o, core_rsp_way_o, ack_req_ready_o, ack_rsp_valid_o,
               mshr_check_o, mshr_check_set_o, mshr_check_tag_o,
               mshr_alloc_o, mshr_alloc_cs_o, mshr_alloc_nline_o, mshr_alloc_id_o,
               mshr_alloc_sid_o, mshr_alloc_word_o, mshr_alloc_need_rsp_o, mshr_alloc_is_pf_o,
               mshr_ack_o, mshr_ack_cs_o, mshr_ack_set_o, mshr_ack_way_o
    );
endinterface

// File: rtl/hpdcache_mshr_ctrl_arb.sv
// hpdcache_mshr_ctrl_arb: ack-over-core priority arbiter bounded by a consecutive-ack streak
module hpdcache_mshr_ctrl_arb #(
    parameter int ACK_STREAK_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic ack_valid_i,
    input  logic core_valid_i,
    output logic gnt_ack_o,
    output logic gnt_core_o
);
    localparam int STREAK_W = $clog2(ACK_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(ACK_STREAK_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Ack wins unless it has already starved a waiting core request for STREAK_MAX grants
    always_comb begin
        gnt_ack_o  = enable_i && ack_valid_i && (!core_valid_i || streak_q < STREAK_MAX);
        gnt_core_o = enable_i && core_valid_i && !gnt_ack_o;
        streak_d   = (!core_valid_i || gnt_core_o) ? '0 :
                     (gnt_ack_o && streak_q < STREAK_MAX) ? streak_q + 1'b1 : streak_q;
    end

    // Streak counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) streak_q <= '0;
        else       streak_q <= streak_d;
    end
endmodule

// File: rtl/hpdcache_mshr_ctrl.sv
// hpdcache_mshr_ctrl: serialises core check/alloc and refill ack onto the single MSHR port
module hpdcache_mshr_ctrl
    import hpdcache_mshr_ctrl_pkg::*;
#(
    parameter int ACK_STREAK_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hpdcache_mshr_ctrl_if.slave  bus
);
    hpdcache_mshr_ctrl_state_e state_q, state_d;
    core_req_t                 req_q, req_d;
    logic                      ack_rsp_q, ack_rsp_d;
    logic                      gnt_ack, gnt_core;
    logic                      in_check, in_alloc;

    // Grants only happen in IDLE and never while reset is held, so no strobe leaks out
    hpdcache_mshr_ctrl_arb #(.ACK_STREAK_MAX(ACK_STREAK_MAX)) u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (state_q == IDLE && !rst_i),
        .ack_valid_i  (bus.ack_req_valid_i),
        .core_valid_i (bus.core_req_valid_i),
        .gnt_ack_o    (gnt_ack),
        .gnt_core_o   (gnt_core)
    );

    assign in_check = state_q == CHECK;
    assign in_alloc = state_q == ALLOC;

    // State, held request and ack-response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            ack_rsp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ack_rsp_q <= ack_rsp_d;
        end
    end

    // Next state: a miss that may allocate goes through ALLOC, everything else returns to IDLE
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = gnt_core ? CHECK : IDLE;
            CHECK:   state_d = (!bus.mshr_hit_i && !bus.mshr_alloc_full_i && req_q.alloc) ? ALLOC : IDLE;
            ALLOC:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the core request on grant so alloc sees the fields the check was made for
    always_comb begin
        req_d     = gnt_core ? '{alloc:    bus.core_req_alloc_i,
                                 nline:    bus.core_req_nline_i,
                                 id:       bus.core_req_id_i,
                                 sid:      bus.core_req_sid_i,
                                 word:     bus.core_req_word_i,
                                 need_rsp: bus.core_req_need_rsp_i,
                                 is_pf:    bus.core_req_is_pf_i} : req_q;
        ack_rsp_d = gnt_ack;
    end

    // MSHR commands and requester responses
    always_comb begin
        bus.core_req_ready_o      = gnt_core;
        bus.ack_req_ready_o       = gnt_ack;
        bus.ack_rsp_valid_o       = ack_rsp_q;
        bus.mshr_check_o          = gnt_core;
        bus.mshr_check_set_o      = nline_set(bus.core_req_nline_i);
        bus.mshr_check_tag_o      = nline_tag(bus.core_req_nline_i);
        bus.mshr_ack_o            = gnt_ack;
        bus.mshr_ack_cs_o         = gnt_ack;
        bus.mshr_ack_set_o        = bus.ack_req_set_i;
        bus.mshr_ack_way_o        = bus.ack_req_way_i;
        bus.mshr_alloc_o          = in_alloc;
        bus.mshr_alloc_cs_o       = in_alloc;
        bus.mshr_alloc_nline_o    = req_q.nline;
        bus.mshr_alloc_id_o       = req_q.id;
        bus.mshr_alloc_sid_o      = req_q.sid;
        bus.mshr_alloc_word_o     = req_q.word;
        bus.mshr_alloc_need_rsp_o = req_q.need_rsp;
        bus.mshr_alloc_is_pf_o    = req_q.is_pf;
        bus.core_rsp_valid_o      = in_alloc || (in_check && (bus.mshr_hit_i || bus.mshr_alloc_full_i || !req_q.alloc));
        bus.core_rsp_hit_o        = in_check && bus.mshr_hit_i;
        bus.core_rsp_full_o       = in_check && !bus.mshr_hit_i && bus.mshr_alloc_full_i;
        bus.core_rsp_alloc_o      = in_alloc;
        bus.core_rsp_way_o        = in_alloc ? bus.mshr_alloc_way_i : '0;
    end
endmodule

// File: tb/tb_hpdcache_mshr_ctrl.sv
// tb_hpdcache_mshr_ctrl: directed scenarios against a small behavioural MSHR
module tb_hpdcache_mshr_ctrl;
    import hpdcache_mshr_ctrl_pkg::*;

    logic clk_i;
    logic rst_i;
    int   total;
    int   bad;

    hpdcache_mshr_ctrl_if bus ();

    hpdcache_mshr_ctrl #(.ACK_STREAK_MAX(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic      v_m [16][WAYS];
    mshr_tag_t t_m [16][WAYS];

    // Behavioural MSHR: check result registered one cycle after the check strobe
    always @(posedge clk_i or posedge rst_i) begin : mshr_model
        logic      h, f;
        mshr_way_t w;
        mshr_set_t s;
        if (rst_i) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < WAYS; j++) begin
                    v_m[i][j] <= 1'b0;
                    t_m[i][j] <= '0;
                end
            bus.mshr_hit_i        <= 1'b0;
            bus.mshr_alloc_full_i <= 1'b0;
            bus.mshr_alloc_way_i  <= '0;
        end else begin
            if (bus.mshr_check_o) begin
                s = bus.mshr_check_set_o;
                h = 1'b0;
                f = 1'b1;
                w = '0;
                for (int j = WAYS - 1; j >= 0; j--) begin
                    if (v_m[s][j] && t_m[s][j] == bus.mshr_check_tag_o) h = 1'b1;
                    if (!v_m[s][j]) begin
                        f = 1'b0;
                        w = mshr_way_t'(j);
                    end
                end
                bus.mshr_hit_i        <= h;
                bus.mshr_alloc_full_i <= f;
                bus.mshr_alloc_way_i  <= w;
            end
            if (bus.mshr_alloc_o) begin
                v_m[nline_set(bus.mshr_alloc_nline_o)][bus.mshr_alloc_way_i] <= 1'b1;
                t_m[nline_set(bus.mshr_alloc_nline_o)][bus.mshr_alloc_way_i] <= nline_tag(bus.mshr_alloc_nline_o);
            end
            if (bus.mshr_ack_o) v_m[bus.mshr_ack_set_o][bus.mshr_ack_way_o] <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic core_drive(input logic valid, input logic alloc, input hpdcache_nline_t nline);
        bus.core_req_valid_i    = valid;
        bus.core_req_alloc_i    = alloc;
        bus.core_req_nline_i    = nline;
        bus.core_req_id_i       = 4'h5;
        bus.core_req_sid_i      = 2'h2;
        bus.core_req_word_i     = 3'h6;
        bus.core_req_need_rsp_i = 1'b1;
        bus.core_req_is_pf_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        core_drive(1'b1, 1'b1, 16'h0123);
        bus.ack_req_valid_i = 1'b1;
        bus.ack_req_set_i   = '0;
        bus.ack_req_way_i   = '0;
        tick();
        tick();
        total++; if (bus.core_req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_core_ready got=%b exp=0", bus.core_req_ready_o); end
        total++; if (bus.ack_req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ack_ready got=%b exp=0", bus.ack_req_ready_o); end
        total++; if ({bus.mshr_check_o, bus.mshr_alloc_o, bus.mshr_ack_o} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b exp=000", {bus.mshr_check_o, bus.mshr_alloc_o, bus.mshr_ack_o}); end
        total++; if ({bus.core_rsp_valid_o, bus.ack_rsp_valid_o} !== 2'b00) begin bad++; $display("FAIL rst_rsp got=%b exp=00", {bus.core_rsp_valid_o, bus.ack_rsp_valid_o}); end
        core_drive(1'b0, 1'b0, '0);
        bus.ack_req_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_alloc();
        core_drive(1'b1, 1'b1, 16'h0123);
        #1;
        total++; if (bus.core_req_ready_o !== 1'b1 || bus.mshr_check_o !== 1'b1) begin bad++; $display("FAIL alloc_grant got=%b%b exp=11", bus.core_req_ready_o, bus.mshr_check_o); end
        total++; if (bus.mshr_check_set_o !== 4'h3 || bus.mshr_check_tag_o !== 12'h012) begin bad++; $display("FAIL alloc_set_tag got=%h/%h exp=3/012", bus.mshr_check_set_o, bus.mshr_check_tag_o); end
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        total++; if (bus.core_rsp_valid_o !== 1'b0 || bus.mshr_alloc_o !== 1'b0) begin bad++; $display("FAIL alloc_check_cycle got=%b%b exp=00", bus.core_rsp_valid_o, bus.mshr_alloc_o); end
        tick();
        total++; if (bus.mshr_alloc_o !== 1'b1 || bus.mshr_alloc_cs_o !== 1'b1) begin bad++; $display("FAIL alloc_strobe got=%b%b exp=11", bus.mshr_alloc_o, bus.mshr_alloc_cs_o); end
        total++; if (bus.mshr_alloc_nline_o !== 16'h0123 || bus.mshr_alloc_id_o !== 4'h5 || bus.mshr_alloc_word_o !== 3'h6) begin bad++; $display("FAIL alloc_fields got=%h/%h/%h exp=0123/5/6", bus.mshr_alloc_nline_o, bus.mshr_alloc_id_o, bus.mshr_alloc_word_o); end
        total++; if ({bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o, bus.core_rsp_way_o} !== 6'b100100) begin bad++; $display("FAIL alloc_rsp got=%b exp=100100", {bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o, bus.core_rsp_way_o}); end
        tick();
        total++; if (bus.core_rsp_valid_o !== 1'b0 || bus.mshr_alloc_o !== 1'b0) begin bad++; $display("FAIL alloc_done got=%b%b exp=00", bus.core_rsp_valid_o, bus.mshr_alloc_o); end
    endtask

    task automatic test_hit();
        core_drive(1'b1, 1'b1, 16'h0123);
        #1;
        total++; if (bus.core_req_ready_o !== 1'b1) begin bad++; $display("FAIL hit_grant got=%b exp=1", bus.core_req_ready_o); end
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        total++; if ({bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o} !== 4'b1100) begin bad++; $display("FAIL hit_rsp got=%b exp=1100", {bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o}); end
        tick();
        total++; if (bus.mshr_alloc_o !== 1'b0 || bus.core_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL hit_no_alloc got=%b%b exp=00", bus.mshr_alloc_o, bus.core_rsp_valid_o); end
    endtask

    task automatic test_full();
        for (int i = 1; i < WAYS; i++) begin
            core_drive(1'b1, 1'b1, 16'((i << 4) | 3));
            #1;
            tick();
            core_drive(1'b0, 1'b0, '0);
            #1;
            tick();
            total++; if (bus.core_rsp_alloc_o !== 1'b1 || bus.core_rsp_way_o !== mshr_way_t'(i)) begin bad++; $display("FAIL fill_way%0d got=%b/%0d exp=1/%0d", i, bus.core_rsp_alloc_o, bus.core_rsp_way_o, i); end
            tick();
        end
        core_drive(1'b1, 1'b1, 16'h0043);
        #1;
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        total++; if ({bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o} !== 4'b1010) begin bad++; $display("FAIL full_rsp got=%b exp=1010", {bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o}); end
        tick();
        total++; if (bus.mshr_alloc_o !== 1'b0 || bus.core_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL full_no_alloc got=%b%b exp=00", bus.mshr_alloc_o, bus.core_rsp_valid_o); end
        core_drive(1'b1, 1'b1, 16'h0023);
        #1;
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        total++; if ({bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o} !== 3'b110) begin bad++; $display("FAIL hit_over_full got=%b exp=110", {bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o}); end
        tick();
        core_drive(1'b1, 1'b0, 16'h0055);
        #1;
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        total++; if ({bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o} !== 4'b1000) begin bad++; $display("FAIL check_only_rsp got=%b exp=1000", {bus.core_rsp_valid_o, bus.core_rsp_hit_o, bus.core_rsp_full_o, bus.core_rsp_alloc_o}); end
        tick();
        total++; if (bus.mshr_alloc_o !== 1'b0 || bus.core_rsp_valid_o !== 1'b0) begin bad++; $display("FAIL check_only_no_alloc got=%b%b exp=00", bus.mshr_alloc_o, bus.core_rsp_valid_o); end
    endtask

    task automatic test_streak();
        logic [11:0] ack_v, core_v, arsp_v;
        core_drive(1'b1, 1'b0, 16'h0077);
        bus.ack_req_valid_i = 1'b1;
        bus.ack_req_set_i   = 4'hf;
        bus.ack_req_way_i   = 2'h0;
        for (int k = 0; k < 12; k++) begin
            #1;
            ack_v[k]  = bus.ack_req_ready_o;
            core_v[k] = bus.core_req_ready_o;
            arsp_v[k] = bus.ack_rsp_valid_o;
            total++; if (int'(bus.mshr_check_o) + int'(bus.mshr_alloc_o) + int'(bus.mshr_ack_o) > 1) begin bad++; $display("FAIL one_cmd cyc=%0d got=%b%b%b exp=at most one", k, bus.mshr_check_o, bus.mshr_alloc_o, bus.mshr_ack_o); end
            tick();
        end
        core_drive(1'b0, 1'b0, '0);
        bus.ack_req_valid_i = 1'b0;
        total++; if (ack_v !== 12'b0011_1100_1111) begin bad++; $display("FAIL streak_ack got=%b exp=001111001111", ack_v); end
        total++; if (core_v !== 12'b0100_0001_0000) begin bad++; $display("FAIL streak_core got=%b exp=010000010000", core_v); end
        total++; if (arsp_v !== 12'b0111_1001_1110) begin bad++; $display("FAIL streak_ack_rsp got=%b exp=011110011110", arsp_v); end
        tick();
    endtask

    task automatic test_busy();
        core_drive(1'b1, 1'b1, 16'h00a8);
        #1;
        total++; if (bus.core_req_ready_o !== 1'b1) begin bad++; $display("FAIL busy_grant got=%b exp=1", bus.core_req_ready_o); end
        tick();
        bus.ack_req_valid_i = 1'b1;
        bus.ack_req_set_i   = 4'he;
        bus.ack_req_way_i   = 2'h1;
        #1;
        total++; if ({bus.ack_req_ready_o, bus.core_req_ready_o, bus.mshr_ack_o} !== 3'b000) begin bad++; $display("FAIL busy_check got=%b exp=000", {bus.ack_req_ready_o, bus.core_req_ready_o, bus.mshr_ack_o}); end
        tick();
        total++; if ({bus.mshr_alloc_o, bus.ack_req_ready_o, bus.core_req_ready_o, bus.mshr_ack_o} !== 4'b1000) begin bad++; $display("FAIL busy_alloc got=%b exp=1000", {bus.mshr_alloc_o, bus.ack_req_ready_o, bus.core_req_ready_o, bus.mshr_ack_o}); end
        tick();
        total++; if ({bus.ack_req_ready_o, bus.mshr_ack_o, bus.mshr_ack_set_o, bus.core_req_ready_o} !== 7'b11_1110_0) begin bad++; $display("FAIL busy_idle_ack got=%b exp=1111100", {bus.ack_req_ready_o, bus.mshr_ack_o, bus.mshr_ack_set_o, bus.core_req_ready_o}); end
        core_drive(1'b0, 1'b0, '0);
        bus.ack_req_valid_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] ack_v, core_v;
        core_drive(1'b1, 1'b1, 16'h00b9);
        #1;
        tick();
        core_drive(1'b0, 1'b0, '0);
        #1;
        tick();
        total++; if (bus.mshr_alloc_o !== 1'b1) begin bad++; $display("FAIL mid_in_alloc got=%b exp=1", bus.mshr_alloc_o); end
        rst_i = 1'b1;
        #1;
        total++; if ({bus.mshr_alloc_o, bus.mshr_alloc_cs_o, bus.core_rsp_valid_o} !== 3'b000) begin bad++; $display("FAIL mid_abort got=%b exp=000", {bus.mshr_alloc_o, bus.mshr_alloc_cs_o, bus.core_rsp_valid_o}); end
        tick();
        rst_i = 1'b0;
        tick();
        total++; if ({bus.mshr_alloc_o, bus.core_rsp_valid_o, bus.mshr_check_o} !== 3'b000) begin bad++; $display("FAIL mid_after got=%b exp=000", {bus.mshr_alloc_o, bus.core_rsp_valid_o, bus.mshr_check_o}); end
        core_drive(1'b1, 1'b0, 16'h00c0);
        bus.ack_req_valid_i = 1'b1;
        bus.ack_req_set_i   = 4'hd;
        bus.ack_req_way_i   = 2'h2;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.ack_req_ready_o !== 1'b1) begin bad++; $display("FAIL prime_ack%0d got=%b exp=1", k, bus.ack_req_ready_o); end
            tick();
        end
        rst_i = 1'b1;
        #1;
        total++; if ({bus.ack_req_ready_o, bus.core_req_ready_o, bus.ack_rsp_valid_o} !== 3'b000) begin bad++; $display("FAIL rst_gates_grants got=%b exp=000", {bus.ack_req_ready_o, bus.core_req_ready_o, bus.ack_rsp_valid_o}); end
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            ack_v[k]  = bus.ack_req_ready_o;
            core_v[k] = bus.core_req_ready_o;
            tick();
        end
        total++; if (ack_v !== 5'b01111 || core_v !== 5'b10000) begin bad++; $display("FAIL streak_cleared got=%b/%b exp=01111/10000", ack_v, core_v); end
        core_drive(1'b0, 1'b0, '0);
        bus.ack_req_valid_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alloc();
        test_hit();
        test_full();
        test_streak();
        test_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
